systolic_seq_ctrl: RTL

Sequencer for the 8×8 output-stationary systolic array behind ChipTop. It turns a single START pulse into a timed run:
- one accumulator-clear cycle;
- a skewed operand feed with per-row and per-column element indices into the data bank (regs 0–7, activations) and the transposed-weight bank (regs 8–F);
- a latched interrupt that the host acknowledges.

It replaces the fixed 24-cycle matmul wait that the host currently counts by hand.

---
 rtl/systolic_pkg.sv | 36 +++
 rtl/skew_lane_decode.sv | 41 ++++
 rtl/systolic_seq_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared constants and types for the 8x8 output-stationary systolic array
// sequencer.
//   N           : array dimension (rows = columns = vector length)
//   IW          : element-index width
//   SW          : feed-step counter width
//   FEED_LAST   : last feed step (3N-3); the run ends after this step
//   DATA_BASE   : register-map base of the activation bank (regs 0-7)
//   WEIGHT_BASE : register-map base of the transposed-weight bank (regs 8-F)
//   seq_state_e : sequencer states
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int N  = 8;
    localparam int IW = $clog2(N);
    localparam int SW = $clog2(3 * N - 1);

    // The last operand pair reaches PE(N-1,N-1) at step (N-1)+(N-1)+(N-1).
    function automatic int feed_last(input int n);
        return 3 * n - 3;
    endfunction

    localparam int FEED_LAST = feed_last(N);

    localparam logic [3:0] DATA_BASE   = 4'h0;
    localparam logic [3:0] WEIGHT_BASE = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        FEED = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/skew_lane_decode.sv
// -----------------------------------------------------------------------------
// skew_lane_decode
// Turns the shared feed step into the skewed per-lane operand window.
// Lane g is inside its window when g <= step <= g+N-1; inside the window it
// reads element (step - g), outside it injects zero.
// Ports:
//   step : current feed step from the sequencer
//   en   : global enable; a stalled cycle injects nothing (vld forced low)
//   feed : sequencer is in its feed phase
//   vld  : per-lane operand-valid, N bits
//   idx  : per-lane element index, N*IW bits, lane g in idx[g*IW +: IW]
// -----------------------------------------------------------------------------
module skew_lane_decode #(
    parameter int N  = 8,
    parameter int IW = $clog2(N),
    parameter int SW = $clog2(3 * N - 1)
) (
    input  logic [SW-1:0]   step,
    input  logic            en,
    input  logic            feed,
    output logic [N-1:0]    vld,
    output logic [N*IW-1:0] idx
);

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        localparam logic [SW:0] LANE_OFS = (SW + 1)'(gi);

        // One extra bit catches step < gi as a borrow, so the window test is
        // a single subtract and compare and never wraps into a bogus index.
        logic [SW:0] diff;
        logic        in_window;

        assign diff      = {1'b0, step} - LANE_OFS;
        assign in_window = feed && !diff[SW] && (diff[SW-1:0] < SW'(N));

        // Indices follow the step even while stalled; only the valid is gated.
        assign vld[gi]             = in_window && en;
        assign idx[gi*IW +: IW]    = in_window ? diff[IW-1:0] : '0;
    end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for the 8x8 output-stationary systolic array. A START pulse runs
// one accumulator-clear cycle, then a skewed operand feed of 3N-2 steps, then
// raises a level interrupt held until the host acknowledges.
// Ports:
//   CLK       : system clock, rising edge
//   CLEAR     : asynchronous active-high reset
//   EN        : global enable; 0 stalls state and STEP
//   START     : single-cycle run request
//   ACK       : host acknowledge, clears INTERRUPT (honoured even when EN=0)
//   A_IDX     : lane i element index into data reg i
//   A_VLD     : lane i injects a valid activation
//   W_IDX     : lane j element index into weight reg 8+j
//   W_VLD     : lane j injects a valid weight
//   PE_EN     : array multiply-accumulates and shifts this cycle
//   PE_CLR    : clear all PE accumulators
//   BUSY      : run in progress (clear or feed phase)
//   INTERRUPT : result ready
//   STEP      : current feed step
// All outputs are decoded from the state and step registers; EN is the only
// input with a combinational path to outputs (it gates the strobes).
// -----------------------------------------------------------------------------
module systolic_seq_ctrl #(
    parameter int N  = systolic_pkg::N,
    parameter int IW = $clog2(N),
    parameter int SW = $clog2(3 * N - 1)
) (
    input  logic            CLK,
    input  logic            CLEAR,
    input  logic            EN,
    input  logic            START,
    input  logic            ACK,
    output logic [N*IW-1:0] A_IDX,
    output logic [N-1:0]    A_VLD,
    output logic [N*IW-1:0] W_IDX,
    output logic [N-1:0]    W_VLD,
    output logic            PE_EN,
    output logic            PE_CLR,
    output logic            BUSY,
    output logic            INTERRUPT,
    output logic [SW-1:0]   STEP
);

    import systolic_pkg::*;

    localparam logic [SW-1:0] STEP_LAST = SW'(feed_last(N));

    seq_state_e    state_reg;
    seq_state_e    state_next;
    logic [SW-1:0] step_reg;
    logic [SW-1:0] step_next;

    // ------------------------------------------------------------------
    // State and step registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_reg <= IDLE;
            step_reg  <= '0;
        end else begin
            state_reg <= state_next;
            step_reg  <= step_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        step_next  = step_reg;
        case (state_reg)
            IDLE: begin
                // A request during a stall is dropped, not queued.
                if (START && EN) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                if (EN) begin
                    state_next = FEED;
                    step_next  = '0;
                end
            end
            FEED: begin
                if (EN) begin
                    if (step_reg == STEP_LAST) begin
                        state_next = DONE;
                        step_next  = '0;
                    end else begin
                        step_next = step_reg + SW'(1);
                    end
                end
            end
            DONE: begin
                // ACK is accepted while stalled; a paired START chains the
                // next run only when the array is allowed to advance.
                if (ACK) begin
                    state_next = (START && EN) ? CLR : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                step_next  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Moore outputs
    // ------------------------------------------------------------------
    logic feed_phase;

    assign feed_phase = (state_reg == FEED);
    assign BUSY       = (state_reg == CLR) || feed_phase;
    assign INTERRUPT  = (state_reg == DONE);
    assign PE_CLR     = (state_reg == CLR) && EN;
    assign PE_EN      = feed_phase && EN;
    assign STEP       = step_reg;

    // Activations and transposed weights share the same skew: row i of the
    // data bank and row j of the weight bank both start at their lane number.
    skew_lane_decode #(
        .N  (N),
        .IW (IW),
        .SW (SW)
    ) u_a_lanes (
        .step (step_reg),
        .en   (EN),
        .feed (feed_phase),
        .vld  (A_VLD),
        .idx  (A_IDX)
    );

    skew_lane_decode #(
        .N  (N),
        .IW (IW),
        .SW (SW)
    ) u_w_lanes (
        .step (step_reg),
        .en   (EN),
        .feed (feed_phase),
        .vld  (W_VLD),
        .idx  (W_IDX)
    );

endmodule
